sevenseg_scan_ctrl: RTL and testbench



---
 rtl/sevenseg_pkg.sv | 21 ++
 rtl/sevenseg_glyph_rom.sv | 43 ++++
 rtl/sevenseg_scan_ctrl.sv | 158 +++++++++++++++
 tb/tb_sevenseg_scan_ctrl.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/sevenseg_pkg.sv
// Shared constants for the multiplexed seven-segment scanner: glyph codes,
// active-high segment patterns and display mode encoding.
package sevenseg_pkg;

    localparam logic [3:0] GLYPH_L     = 4'hA;
    localparam logic [3:0] GLYPH_C     = 4'hB;
    localparam logic [3:0] GLYPH_R     = 4'hC;
    localparam logic [3:0] GLYPH_O     = 4'hD;
    localparam logic [3:0] GLYPH_DASH  = 4'hE;
    localparam logic [3:0] GLYPH_BLANK = 4'hF;

    // Segment order {g,f,e,d,c,b,a}, active-high
    localparam logic [6:0] SEG_OFF  = 7'h00;
    localparam logic [6:0] SEG_ZERO = 7'h3F;

    typedef enum logic {
        MODE_HEX   = 1'b0,
        MODE_GLYPH = 1'b1
    } mode_e;

endpackage

// File: rtl/sevenseg_glyph_rom.sv
// Combinational nibble + mode to active-high segment pattern {g,f,e,d,c,b,a}.
module sevenseg_glyph_rom
    import sevenseg_pkg::*;
(
    input  logic [3:0] nib_i,
    input  logic       mode_i,
    output logic [6:0] seg_c_o
);

    always_comb begin
        seg_c_o = SEG_OFF;
        if (mode_i == MODE_GLYPH && nib_i >= GLYPH_L) begin
            unique case (nib_i)
                GLYPH_L:    seg_c_o = 7'h38;
                GLYPH_C:    seg_c_o = 7'h39;
                GLYPH_R:    seg_c_o = 7'h50;
                GLYPH_O:    seg_c_o = 7'h5C;
                GLYPH_DASH: seg_c_o = 7'h40;
                default:    seg_c_o = SEG_OFF;
            endcase
        end else begin
            unique case (nib_i)
                4'h0:    seg_c_o = SEG_ZERO;
                4'h1:    seg_c_o = 7'h06;
                4'h2:    seg_c_o = 7'h5B;
                4'h3:    seg_c_o = 7'h4F;
                4'h4:    seg_c_o = 7'h66;
                4'h5:    seg_c_o = 7'h6D;
                4'h6:    seg_c_o = 7'h7D;
                4'h7:    seg_c_o = 7'h07;
                4'h8:    seg_c_o = 7'h7F;
                4'h9:    seg_c_o = 7'h6F;
                4'hA:    seg_c_o = 7'h77;
                4'hB:    seg_c_o = 7'h7C;
                4'hC:    seg_c_o = 7'h39;
                4'hD:    seg_c_o = 7'h5E;
                4'hE:    seg_c_o = 7'h79;
                default: seg_c_o = 7'h71;
            endcase
        end
    end

endmodule

// File: rtl/sevenseg_scan_ctrl.sv
// Multiplexed N-digit seven-segment scanner with per-frame input snapshots,
// blinking, leading-zero suppression and an anode guard at each slot start.
module sevenseg_scan_ctrl
    import sevenseg_pkg::*;
#(
    parameter int unsigned N_DIGITS     = 4,
    parameter int unsigned PRESCALE_W   = 18,
    parameter int unsigned GUARD_CYCLES = 64,
    parameter int unsigned BLINK_LOG2   = 5,
    parameter bit          ACTIVE_LOW   = 1'b1,
    parameter bit          LZ_SUPPRESS  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*N_DIGITS-1:0] value_i,
    input  logic                  mode_i,
    input  logic [N_DIGITS-1:0]   blink_en_i,
    input  logic [N_DIGITS-1:0]   dp_en_i,
    output logic [6:0]            seg_o,
    output logic                  dp_o,
    output logic [N_DIGITS-1:0]   an_o,
    output logic                  frame_start_o
);

    localparam int unsigned IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int unsigned VAL_W = 4 * N_DIGITS;
    localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(N_DIGITS - 1);
    localparam logic [6:0]          SEG_POL  = ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [N_DIGITS-1:0] AN_POL   = {N_DIGITS{ACTIVE_LOW}};

    logic [PRESCALE_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [BLINK_LOG2-1:0] fcnt_q, fcnt_d;
    logic                  phase_q, phase_d;
    logic [VAL_W-1:0]      snap_val_q, snap_val_d;
    logic                  snap_mode_q, snap_mode_d;
    logic [N_DIGITS-1:0]   snap_blink_q, snap_blink_d;
    logic [N_DIGITS-1:0]   snap_dp_q, snap_dp_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [N_DIGITS-1:0]   an_q, an_d;
    logic                  fs_q, fs_d;

    logic                  tick;
    logic                  wrap;
    logic                  guard;
    logic [3:0]            cur_nib;
    logic                  cur_blink;
    logic                  cur_dp;
    logic                  lz_keep;
    logic                  blank;
    logic [6:0]            glyph_seg;
    logic [6:0]            seg_hi;
    logic                  dp_hi;
    logic [N_DIGITS-1:0]   an_hi;

    // Timebase: slot counter, digit index, frame snapshot and blink phase
    always_comb begin
        tick         = (cnt_q == '1);
        wrap         = tick && (idx_q == IDX_LAST);
        cnt_d        = cnt_q + PRESCALE_W'(1);
        idx_d        = idx_q;
        fcnt_d       = fcnt_q;
        phase_d      = phase_q;
        snap_val_d   = snap_val_q;
        snap_mode_d  = snap_mode_q;
        snap_blink_d = snap_blink_q;
        snap_dp_d    = snap_dp_q;
        fs_d         = wrap;
        if (tick) begin
            idx_d = wrap ? '0 : idx_q + IDX_W'(1);
        end
        if (wrap) begin
            snap_val_d   = value_i;
            snap_mode_d  = mode_i;
            snap_blink_d = blink_en_i;
            snap_dp_d    = dp_en_i;
            fcnt_d       = fcnt_q + BLINK_LOG2'(1);
            if (fcnt_q == '1) begin
                phase_d = ~phase_q;
            end
        end
    end

    // Current-digit selection; lz_keep is set if this or any higher digit is non-zero
    always_comb begin
        cur_nib   = 4'h0;
        cur_blink = 1'b0;
        cur_dp    = 1'b0;
        lz_keep   = 1'b0;
        guard     = (cnt_q < PRESCALE_W'(GUARD_CYCLES));
        an_hi     = '0;
        for (int k = 0; k < int'(N_DIGITS); k++) begin
            if (idx_q == IDX_W'(k)) begin
                cur_nib   = snap_val_q[k*4 +: 4];
                cur_blink = snap_blink_q[k];
                cur_dp    = snap_dp_q[k];
                an_hi[k]  = ~guard;
            end
            if (IDX_W'(k) >= idx_q && snap_val_q[k*4 +: 4] != 4'h0) begin
                lz_keep = 1'b1;
            end
        end
    end

    sevenseg_glyph_rom u_glyph_rom (
        .nib_i   (cur_nib),
        .mode_i  (snap_mode_q),
        .seg_c_o (glyph_seg)
    );

    // Blanking (blink over LZ over decode), then output polarity
    always_comb begin
        blank = (cur_blink && phase_q)
              || (LZ_SUPPRESS && snap_mode_q == MODE_HEX && idx_q != '0 && !lz_keep);
        seg_hi = blank ? SEG_OFF : glyph_seg;
        dp_hi  = cur_dp && !blank;
        seg_d  = seg_hi ^ SEG_POL;
        dp_d   = dp_hi ^ ACTIVE_LOW;
        an_d   = an_hi ^ AN_POL;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            fcnt_q       <= '0;
            phase_q      <= 1'b0;
            snap_val_q   <= '0;
            snap_mode_q  <= 1'b0;
            snap_blink_q <= '0;
            snap_dp_q    <= '0;
            seg_q        <= SEG_POL;
            dp_q         <= ACTIVE_LOW;
            an_q         <= AN_POL;
            fs_q         <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            fcnt_q       <= fcnt_d;
            phase_q      <= phase_d;
            snap_val_q   <= snap_val_d;
            snap_mode_q  <= snap_mode_d;
            snap_blink_q <= snap_blink_d;
            snap_dp_q    <= snap_dp_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            an_q         <= an_d;
            fs_q         <= fs_d;
        end
    end

    assign seg_o         = seg_q;
    assign dp_o          = dp_q;
    assign an_o          = an_q;
    assign frame_start_o = fs_q;

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Directed bench: 4-digit active-low scanner (A) and 3-digit active-high scanner (B),
// both with 8-cycle slots and a 1-cycle anode guard.
module tb_sevenseg_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_a, rst_b;
    logic [15:0] value_a;
    logic        mode_a;
    logic [3:0]  blink_a, dpen_a;
    logic [6:0]  seg_a;
    logic        dp_a;
    logic [3:0]  an_a;
    logic        fs_a;
    logic [11:0] value_b;
    logic [6:0]  seg_b;
    logic        dp_b;
    logic [2:0]  an_b;
    logic        fs_b;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    sevenseg_scan_ctrl #(
        .N_DIGITS(4), .PRESCALE_W(3), .GUARD_CYCLES(1),
        .BLINK_LOG2(1), .ACTIVE_LOW(1'b1), .LZ_SUPPRESS(1'b1)
    ) u_dut_a (
        .clk(clk), .rst(rst_a), .value_i(value_a), .mode_i(mode_a),
        .blink_en_i(blink_a), .dp_en_i(dpen_a), .seg_o(seg_a), .dp_o(dp_a),
        .an_o(an_a), .frame_start_o(fs_a)
    );

    sevenseg_scan_ctrl #(
        .N_DIGITS(3), .PRESCALE_W(3), .GUARD_CYCLES(1),
        .BLINK_LOG2(1), .ACTIVE_LOW(1'b0), .LZ_SUPPRESS(1'b1)
    ) u_dut_b (
        .clk(clk), .rst(rst_b), .value_i(value_b), .mode_i(1'b0),
        .blink_en_i(3'b000), .dp_en_i(3'b000), .seg_o(seg_b), .dp_o(dp_b),
        .an_o(an_b), .frame_start_o(fs_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] an_cur(input bit b);
        return b ? 8'(an_b) : 8'(an_a);
    endfunction
    function automatic logic [6:0] seg_cur(input bit b);
        return b ? seg_b : seg_a;
    endfunction
    function automatic logic dp_cur(input bit b);
        return b ? dp_b : dp_a;
    endfunction
    function automatic logic fs_cur(input bit b);
        return b ? fs_b : fs_a;
    endfunction

    // Entered at slot offset 8k (negedge); guard cycle, lit cycle, then on to 8k+8
    task automatic scan_digit(input bit b, input int k, input logic [6:0] exp_seg, input logic exp_dp);
        logic [7:0] an_off;
        logic [7:0] an_on;
        an_off = b ? 8'h00 : 8'h0F;
        an_on  = b ? (8'd1 << k) : (8'h0F & ~(8'd1 << k));
        @(negedge clk);
        check_eq($sformatf("guard_an%0d_d%0d", b, k), an_cur(b), an_off);
        check_eq($sformatf("guard_seg%0d_d%0d", b, k), seg_cur(b), exp_seg);
        check_eq($sformatf("fs_low%0d_d%0d", b, k), fs_cur(b), 1'b0);
        @(negedge clk);
        check_eq($sformatf("an%0d_d%0d", b, k), an_cur(b), an_on);
        check_eq($sformatf("seg%0d_d%0d", b, k), seg_cur(b), exp_seg);
        check_eq($sformatf("dp%0d_d%0d", b, k), dp_cur(b), exp_dp);
        repeat (6) @(negedge clk);
    endtask

    // segs packed {d3,d2,d1,d0} (7 bits each), dps {d3..d0} as raw dp_o values
    task automatic frame_part(input bit b, input int n, input int lo, input int hi,
                              input logic [27:0] segs, input logic [3:0] dps);
        for (int k = lo; k <= hi; k++) begin
            scan_digit(b, k, segs[k*7 +: 7], dps[k]);
        end
        if (hi == n - 1) begin
            check_eq($sformatf("fs_high%0d", b), fs_cur(b), 1'b1);
        end
    endtask

    // Waits for the first frame_start after release; also checks the pre-snapshot display
    task automatic wait_first_fs(input bit b, input int exp_lat, input logic [7:0] an2, input logic [6:0] seg2);
        int lat;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 2) begin
                check_eq($sformatf("presnap_an%0d", b), an_cur(b), an2);
                check_eq($sformatf("presnap_seg%0d", b), seg_cur(b), seg2);
            end
        end while (!fs_cur(b) && lat < 80);
        check_eq($sformatf("fs_latency%0d", b), lat, exp_lat);
    endtask

    initial begin
        rst_a   = 1'b1;
        rst_b   = 1'b1;
        value_a = 16'h1234;
        mode_a  = 1'b0;
        blink_a = 4'b0000;
        dpen_a  = 4'b0000;
        value_b = 12'h210;

        repeat (3) begin
            @(negedge clk);
            check_eq("rst_an_a", an_a, 4'b1111);
            check_eq("rst_seg_a", seg_a, 7'h7F);
            check_eq("rst_dp_a", dp_a, 1'b1);
            check_eq("rst_fs_a", fs_a, 1'b0);
        end
        check_eq("rst_an_b", an_b, 3'b000);
        check_eq("rst_seg_b", seg_b, 7'h00);
        rst_a = 1'b0;

        wait_first_fs(1'b0, 32, 8'h0E, 7'h40);

        // Frame 1: 1234, input changed during digit 2's slot must not tear it
        frame_part(0, 4, 0, 1, {7'h79, 7'h24, 7'h30, 7'h19}, 4'hF);
        value_a = 16'h5678;
        frame_part(0, 4, 2, 3, {7'h79, 7'h24, 7'h30, 7'h19}, 4'hF);
        // Frame 2: 5678
        frame_part(0, 4, 0, 0, {7'h12, 7'h02, 7'h78, 7'h00}, 4'hF);
        mode_a  = 1'b1;
        value_a = 16'hABCD;
        frame_part(0, 4, 1, 3, {7'h12, 7'h02, 7'h78, 7'h00}, 4'hF);
        // Frame 3: glyphs o r C L
        frame_part(0, 4, 0, 0, {7'h47, 7'h46, 7'h2F, 7'h23}, 4'hF);
        value_a = 16'hFFFF;
        frame_part(0, 4, 1, 3, {7'h47, 7'h46, 7'h2F, 7'h23}, 4'hF);
        // Frame 4: glyph blanks
        frame_part(0, 4, 0, 0, {7'h7F, 7'h7F, 7'h7F, 7'h7F}, 4'hF);
        mode_a  = 1'b0;
        value_a = 16'h0040;
        frame_part(0, 4, 1, 3, {7'h7F, 7'h7F, 7'h7F, 7'h7F}, 4'hF);
        // Frame 5: leading zeros above digit 1 suppressed
        frame_part(0, 4, 0, 0, {7'h7F, 7'h7F, 7'h19, 7'h40}, 4'hF);
        value_a = 16'h0000;
        frame_part(0, 4, 1, 3, {7'h7F, 7'h7F, 7'h19, 7'h40}, 4'hF);
        // Frame 6: all zero, only digit 0 shows "0"
        frame_part(0, 4, 0, 0, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'hF);
        value_a = 16'h1234;
        blink_a = 4'b0001;
        dpen_a  = 4'b0001;
        frame_part(0, 4, 1, 3, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'hF);
        // Frames 7..11: blink phase dark, lit, lit, dark, dark
        frame_part(0, 4, 0, 3, {7'h79, 7'h24, 7'h30, 7'h7F}, 4'hF);
        frame_part(0, 4, 0, 3, {7'h79, 7'h24, 7'h30, 7'h19}, 4'hE);
        frame_part(0, 4, 0, 3, {7'h79, 7'h24, 7'h30, 7'h19}, 4'hE);
        frame_part(0, 4, 0, 3, {7'h79, 7'h24, 7'h30, 7'h7F}, 4'hF);
        frame_part(0, 4, 0, 3, {7'h79, 7'h24, 7'h30, 7'h7F}, 4'hF);

        // Instance B: 3 digits, active-high, index wraps 2 -> 0
        rst_b = 1'b0;
        wait_first_fs(1'b1, 24, 8'h01, 7'h3F);
        frame_part(1, 3, 0, 2, {7'h00, 7'h5B, 7'h06, 7'h3F}, 4'h0);
        frame_part(1, 3, 0, 0, {7'h00, 7'h5B, 7'h06, 7'h3F}, 4'h0);
        repeat (3) @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);
        check_eq("midrst_an_b", an_b, 3'b000);
        check_eq("midrst_seg_b", seg_b, 7'h00);
        check_eq("midrst_dp_b", dp_b, 1'b0);
        check_eq("midrst_fs_b", fs_b, 1'b0);
        rst_b = 1'b0;
        wait_first_fs(1'b1, 24, 8'h01, 7'h3F);
        frame_part(1, 3, 0, 2, {7'h00, 7'h5B, 7'h06, 7'h3F}, 4'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
